issue_queue_wakeup: RTL and testbench

- Parametrised multi-entry issue queue: holds renamed micro-ops until both source PRF tags are ready, then issues them oldest-first.
- Woken by up to NUM_CDB common-data-bus broadcasts per cycle.
- Sits between rename/dispatch and the execution units; successor to the single-entry, single-CDB issue controller.
- Adds:
  - buffering depth,
  - multi-channel wakeup,
  - same-cycle dispatch/CDB bypass,
  - issue backpressure,
  - flush.

---
 rtl/issue_queue_wakeup_pkg.sv | 36 +++
 rtl/issue_queue_wakeup_wakeup_cmp.sv | 32 +++
 rtl/issue_queue_wakeup.sv | 210 +++++++++++++++++++++
 tb/tb_issue_queue_wakeup.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_wakeup_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : issue_queue_wakeup_pkg
//  Brief    : Shared widths, entry layout and helpers for the wakeup issue
//             queue and its tag comparator.
//  Revision : 1.0 - initial release
// ============================================================================
package issue_queue_wakeup_pkg;

  // Default tag / opcode / channel widths; the top-level parameters default
  // to these and the stored entry layout is built from them.
  localparam int PRF_W_DEF   = 6;
  localparam int OP_W_DEF    = 5;
  localparam int NUM_CDB_DEF = 2;

  // Width of the packed CDB tag bus for the default configuration.
  localparam int CDB_W = NUM_CDB_DEF * PRF_W_DEF;

  // One queue slot.
  typedef struct packed {
    logic                 valid;
    logic [OP_W_DEF-1:0]  opcode;
    logic [PRF_W_DEF-1:0] src1_prf;
    logic                 src1_rdy;
    logic [PRF_W_DEF-1:0] src2_prf;
    logic                 src2_rdy;
    logic [PRF_W_DEF-1:0] dest_prf;
  } iq_entry_t;

  // An entry may be selected once it is occupied and both operands are ready.
  function automatic logic entry_issuable(input iq_entry_t e);
    return e.valid & e.src1_rdy & e.src2_rdy;
  endfunction

endpackage
`default_nettype wire

// File: rtl/issue_queue_wakeup_wakeup_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : iq_wakeup_cmp
//  Brief    : Compares one source tag against every CDB channel; asserts
//             match when any valid channel carries the same tag.
//  Revision : 1.0 - initial release
// ============================================================================
module iq_wakeup_cmp
  import issue_queue_wakeup_pkg::*;
#(
  parameter int NUM_CDB  = NUM_CDB_DEF,
  parameter int PRF_W    = PRF_W_DEF,
  parameter int CDB_BITS = CDB_W
) (
  input  logic [PRF_W-1:0]    tag_i,
  input  logic [NUM_CDB-1:0]  cdb_valid_i,
  input  logic [CDB_BITS-1:0] cdb_tag_i,
  output logic                match_o
);

  // OR-reduce the per-channel equality; duplicate tags simply match twice.
  always_comb begin
    match_o = 1'b0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (cdb_valid_i[k] && (cdb_tag_i[k*PRF_W +: PRF_W] == tag_i)) begin
        match_o = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/issue_queue_wakeup.sv
`default_nettype none
// ============================================================================
//  Module   : issue_queue_wakeup
//  Brief    : Collapsing, oldest-first issue queue with multi-channel CDB
//             wakeup, same-cycle dispatch bypass, issue backpressure and
//             synchronous flush.
//  Revision : 1.0 - initial release
// ============================================================================
module issue_queue_wakeup
  import issue_queue_wakeup_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = NUM_CDB_DEF,
  parameter int PRF_W   = PRF_W_DEF,   // must equal PRF_W_DEF (entry layout)
  parameter int OP_W    = OP_W_DEF,    // must equal OP_W_DEF (entry layout)
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  // dispatch side
  input  logic                       disp_valid,
  output logic                       disp_ready,
  input  logic [OP_W-1:0]            disp_opcode,
  input  logic [PRF_W-1:0]           disp_src1_prf,
  input  logic                       disp_src1_ready,
  input  logic [PRF_W-1:0]           disp_src2_prf,
  input  logic                       disp_src2_ready,
  input  logic [PRF_W-1:0]           disp_dest_prf,
  // wakeup broadcasts
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*PRF_W-1:0]   cdb_tag,
  // issue side
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [OP_W-1:0]            issue_opcode,
  output logic [PRF_W-1:0]           issue_src1_prf,
  output logic [PRF_W-1:0]           issue_src2_prf,
  output logic [PRF_W-1:0]           issue_dest_prf,
  output logic [CNT_W-1:0]           count
);

  localparam int c_cdb_w = NUM_CDB * PRF_W;
  localparam int c_idx_w = $clog2(DEPTH);

  iq_entry_t          entries_q [DEPTH];
  iq_entry_t          entries_d [DEPTH];
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;

  logic [DEPTH-1:0]   w_match1;
  logic [DEPTH-1:0]   w_match2;
  logic               w_disp_match1;
  logic               w_disp_match2;

  iq_entry_t          w_woke  [DEPTH];
  iq_entry_t          w_upper [DEPTH];
  iq_entry_t          w_new;
  iq_entry_t          w_sel_entry;
  logic               w_sel_found;
  logic [c_idx_w-1:0] w_sel_idx;
  logic               w_fire;
  logic               w_accept;
  logic [CNT_W-1:0]   w_tail;

  // Per-slot wakeup comparators, one per source operand.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry_cmp
      iq_wakeup_cmp #(
        .NUM_CDB  (NUM_CDB),
        .PRF_W    (PRF_W),
        .CDB_BITS (c_cdb_w)
      ) u_cmp_src1 (
        .tag_i       (entries_q[i].src1_prf),
        .cdb_valid_i (cdb_valid),
        .cdb_tag_i   (cdb_tag),
        .match_o     (w_match1[i])
      );
      iq_wakeup_cmp #(
        .NUM_CDB  (NUM_CDB),
        .PRF_W    (PRF_W),
        .CDB_BITS (c_cdb_w)
      ) u_cmp_src2 (
        .tag_i       (entries_q[i].src2_prf),
        .cdb_valid_i (cdb_valid),
        .cdb_tag_i   (cdb_tag),
        .match_o     (w_match2[i])
      );
    end
  endgenerate

  // Bypass comparators: catch a broadcast that lands in the dispatch cycle.
  iq_wakeup_cmp #(
    .NUM_CDB  (NUM_CDB),
    .PRF_W    (PRF_W),
    .CDB_BITS (c_cdb_w)
  ) u_cmp_disp1 (
    .tag_i       (disp_src1_prf),
    .cdb_valid_i (cdb_valid),
    .cdb_tag_i   (cdb_tag),
    .match_o     (w_disp_match1)
  );

  iq_wakeup_cmp #(
    .NUM_CDB  (NUM_CDB),
    .PRF_W    (PRF_W),
    .CDB_BITS (c_cdb_w)
  ) u_cmp_disp2 (
    .tag_i       (disp_src2_prf),
    .cdb_valid_i (cdb_valid),
    .cdb_tag_i   (cdb_tag),
    .match_o     (w_disp_match2)
  );

  // Select the lowest-index issuable slot using the stored ready bits only,
  // so a broadcast becomes visible to select one cycle later.
  always_comb begin
    w_sel_found = 1'b0;
    w_sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entry_issuable(entries_q[i])) begin
        w_sel_found = 1'b1;
        w_sel_idx   = c_idx_w'(i);
      end
    end
  end

  assign w_sel_entry = entries_q[w_sel_idx];

  // Present the selected slot; all fields forced to zero when nothing is ready.
  always_comb begin
    issue_valid    = w_sel_found;
    issue_opcode   = w_sel_found ? w_sel_entry.opcode   : '0;
    issue_src1_prf = w_sel_found ? w_sel_entry.src1_prf : '0;
    issue_src2_prf = w_sel_found ? w_sel_entry.src2_prf : '0;
    issue_dest_prf = w_sel_found ? w_sel_entry.dest_prf : '0;
  end

  // A full queue never accepts, even if a slot frees up this same cycle.
  assign disp_ready = (count_q < CNT_W'(DEPTH)) && !flush;
  assign w_accept   = disp_valid && disp_ready;
  assign w_fire     = w_sel_found && issue_ready && !flush;
  assign w_tail     = count_q - CNT_W'(w_fire);
  assign count      = count_q;

  // Incoming entry with its ready bits already merged with the bypass match.
  always_comb begin
    w_new          = '0;
    w_new.valid    = 1'b1;
    w_new.opcode   = disp_opcode;
    w_new.src1_prf = disp_src1_prf;
    w_new.src1_rdy = disp_src1_ready | w_disp_match1;
    w_new.src2_prf = disp_src2_prf;
    w_new.src2_rdy = disp_src2_ready | w_disp_match2;
    w_new.dest_prf = disp_dest_prf;
  end

  // Next queue image: wake, collapse over the fired slot, then append at tail.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      w_woke[i]          = entries_q[i];
      w_woke[i].src1_rdy = entries_q[i].src1_rdy | w_match1[i];
      w_woke[i].src2_rdy = entries_q[i].src2_rdy | w_match2[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      w_upper[i] = w_woke[i+1];
    end
    w_upper[DEPTH-1] = '0;

    for (int i = 0; i < DEPTH; i++) begin
      if (w_fire && (c_idx_w'(i) >= w_sel_idx)) begin
        entries_d[i] = w_upper[i];
      end else begin
        entries_d[i] = w_woke[i];
      end
      if (w_accept && (w_tail == CNT_W'(i))) begin
        entries_d[i] = w_new;
      end
      if (flush) begin
        entries_d[i] = '0;
      end
    end
  end

  // Occupancy: +1 on accept, -1 on fire, cleared by flush.
  always_comb begin
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(w_accept) - CNT_W'(w_fire);
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_issue_queue_wakeup.sv
`default_nettype none
// ============================================================================
//  Module   : tb_issue_queue_wakeup
//  Brief    : Table-driven self-checking bench for issue_queue_wakeup.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_issue_queue_wakeup;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        disp_valid;
  logic        disp_ready;
  logic [4:0]  disp_opcode;
  logic [5:0]  disp_src1_prf;
  logic        disp_src1_ready;
  logic [5:0]  disp_src2_prf;
  logic        disp_src2_ready;
  logic [5:0]  disp_dest_prf;
  logic [1:0]  cdb_valid;
  logic [11:0] cdb_tag;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_opcode;
  logic [5:0]  issue_src1_prf;
  logic [5:0]  issue_src2_prf;
  logic [5:0]  issue_dest_prf;
  logic [3:0]  count;

  issue_queue_wakeup #(
    .DEPTH   (8),
    .NUM_CDB (2),
    .PRF_W   (6),
    .OP_W    (5)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .flush           (flush),
    .disp_valid      (disp_valid),
    .disp_ready      (disp_ready),
    .disp_opcode     (disp_opcode),
    .disp_src1_prf   (disp_src1_prf),
    .disp_src1_ready (disp_src1_ready),
    .disp_src2_prf   (disp_src2_prf),
    .disp_src2_ready (disp_src2_ready),
    .disp_dest_prf   (disp_dest_prf),
    .cdb_valid       (cdb_valid),
    .cdb_tag         (cdb_tag),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_opcode    (issue_opcode),
    .issue_src1_prf  (issue_src1_prf),
    .issue_src2_prf  (issue_src2_prf),
    .issue_dest_prf  (issue_dest_prf),
    .count           (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs expected during that cycle.
  typedef struct {
    logic        fl;
    logic        dv;
    logic [4:0]  op;
    logic [5:0]  s1;
    logic        s1r;
    logic [5:0]  s2;
    logic        s2r;
    logic [5:0]  d;
    logic [1:0]  cv;
    logic [11:0] ct;
    logic        ir;
    logic        eiv;
    logic [4:0]  eop;
    logic [5:0]  es1;
    logic [5:0]  es2;
    logic [5:0]  ed;
    logic [3:0]  ec;
    logic        edr;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push(
    input logic fl, input logic dv, input logic [4:0] op,
    input logic [5:0] s1, input logic s1r, input logic [5:0] s2, input logic s2r,
    input logic [5:0] d, input logic [1:0] cv, input logic [11:0] ct, input logic ir,
    input logic eiv, input logic [4:0] eop, input logic [5:0] es1, input logic [5:0] es2,
    input logic [5:0] ed, input logic [3:0] ec, input logic edr);
    vec_t v;
    v.fl = fl; v.dv = dv; v.op = op; v.s1 = s1; v.s1r = s1r; v.s2 = s2; v.s2r = s2r;
    v.d = d; v.cv = cv; v.ct = ct; v.ir = ir;
    v.eiv = eiv; v.eop = eop; v.es1 = es1; v.es2 = es2; v.ed = ed; v.ec = ec; v.edr = edr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    flush           = v.fl;
    disp_valid      = v.dv;
    disp_opcode     = v.op;
    disp_src1_prf   = v.s1;
    disp_src1_ready = v.s1r;
    disp_src2_prf   = v.s2;
    disp_src2_ready = v.s2r;
    disp_dest_prf   = v.d;
    cdb_valid       = v.cv;
    cdb_tag         = v.ct;
    issue_ready     = v.ir;
  endtask

  task automatic idle(input logic ir);
    flush = 1'b0; disp_valid = 1'b0; disp_opcode = '0;
    disp_src1_prf = '0; disp_src1_ready = 1'b0;
    disp_src2_prf = '0; disp_src2_ready = 1'b0;
    disp_dest_prf = '0; cdb_valid = '0; cdb_tag = '0;
    issue_ready = ir;
  endtask

  task automatic check_row(input vec_t v, input int idx);
    chk("issue_valid", idx, 32'(issue_valid), 32'(v.eiv));
    chk("issue_opcode", idx, 32'(issue_opcode), 32'(v.eop));
    chk("issue_src1", idx, 32'(issue_src1_prf), 32'(v.es1));
    chk("issue_src2", idx, 32'(issue_src2_prf), 32'(v.es2));
    chk("issue_dest", idx, 32'(issue_dest_prf), 32'(v.ed));
    chk("count", idx, 32'(count), 32'(v.ec));
    chk("disp_ready", idx, 32'(disp_ready), 32'(v.edr));
  endtask

  initial begin
    // ---------------- vector table ----------------
    // ready at dispatch
    push(0,1, 3, 6,1, 7,1, 12, 2'b00, 12'h0, 1,   0, 0, 0, 0, 0, 0,1);
    push(0,0, 0, 0,0, 0,0,  0, 2'b00, 12'h0, 1,   1, 3, 6, 7,12, 1,1);
    push(0,0, 0, 0,0, 0,0,  0, 2'b00, 12'h0, 1,   0, 0, 0, 0, 0, 0,1);
    // multi-CDB wakeup: visible one cycle after the broadcast
    push(0,1, 4,10,0,11,0, 13, 2'b00, 12'h0, 1,   0, 0, 0, 0, 0, 0,1);
    push(0,0, 0, 0,0, 0,0,  0, 2'b11, {6'd11,6'd10}, 1, 0,0,0,0,0, 1,1);
    push(0,0, 0, 0,0, 0,0,  0, 2'b00, 12'h0, 1,   1, 4,10,11,13, 1,1);
    push(0,0, 0, 0,0, 0,0,  0, 2'b00, 12'h0, 1,   0, 0, 0, 0, 0, 0,1);
    // same-cycle dispatch bypass on channel 1
    push(0,1, 5,20,0,21,1, 14, 2'b10, {6'd20,6'd0}, 1, 0,0,0,0,0, 0,1);
    push(0,0, 0, 0,0, 0,0,  0, 2'b00, 12'h0, 1,   1, 5,20,21,14, 1,1);
    push(0,0, 0, 0,0, 0,0,  0, 2'b00, 12'h0, 1,   0, 0, 0, 0, 0, 0,1);
    // oldest-first with backpressure
    push(0,1, 6,30,0,31,1, 15, 2'b00, 12'h0, 0,   0, 0, 0, 0, 0, 0,1);
    push(0,1, 7,32,0,33,1, 16, 2'b00, 12'h0, 0,   0, 0, 0, 0, 0, 1,1);
    push(0,1, 8,34,0,35,1, 17, 2'b00, 12'h0, 0,   0, 0, 0, 0, 0, 2,1);
    push(0,0, 0, 0,0, 0,0,  0, 2'b11, {6'd34,6'd34}, 0, 0,0,0,0,0, 3,1);
    push(0,0, 0, 0,0, 0,0,  0, 2'b10, {6'd30,6'd0},  0, 1,8,34,35,17, 3,1);
    push(0,0, 0, 0,0, 0,0,  0, 2'b00, 12'h0, 0,   1, 6,30,31,15, 3,1);
    push(0,0, 0, 0,0, 0,0,  0, 2'b00, 12'h0, 0,   1, 6,30,31,15, 3,1);
    push(0,0, 0, 0,0, 0,0,  0, 2'b00, 12'h0, 1,   1, 6,30,31,15, 3,1);
    push(0,0, 0, 0,0, 0,0,  0, 2'b00, 12'h0, 1,   1, 8,34,35,17, 2,1);
    push(0,0, 0, 0,0, 0,0,  0, 2'b00, 12'h0, 0,   0, 0, 0, 0, 0, 1,1);
    push(1,0, 0, 0,0, 0,0,  0, 2'b00, 12'h0, 0,   0, 0, 0, 0, 0, 1,0);
    push(0,0, 0, 0,0, 0,0,  0, 2'b00, 12'h0, 0,   0, 0, 0, 0, 0, 0,1);
    // fill to full, fire while full, then flush
    push(0,1, 9, 1,1, 2,1, 40, 2'b00, 12'h0, 0,   0, 0, 0, 0, 0, 0,1);
    for (int k = 1; k <= 7; k++) begin
      push(0,1, 9,50,0,51,0, 6'(40+k), 2'b00, 12'h0, 0, 1, 9, 1, 2,40, 4'(k),1);
    end
    push(0,1, 9,50,0,51,0, 48, 2'b00, 12'h0, 1,   1, 9, 1, 2,40, 8,0);
    push(0,0, 0, 0,0, 0,0,  0, 2'b00, 12'h0, 0,   0, 0, 0, 0, 0, 7,1);
    push(1,1, 9,50,0,51,0, 49, 2'b01, {6'd0,6'd50}, 1, 0,0,0,0,0, 7,0);
    push(0,0, 0, 0,0, 0,0,  0, 2'b00, 12'h0, 0,   0, 0, 0, 0, 0, 0,1);

    // ---------------- reset state ----------------
    reset_n = 1'b0;
    idle(1'b0);
    #2;
    chk("rst_issue_valid", -1, 32'(issue_valid), 32'd0);
    chk("rst_count", -1, 32'(count), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_disp_ready", -1, 32'(disp_ready), 32'd1);

    // ---------------- table loop ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      check_row(vecs[i], i);
    end

    // ---------------- reset mid-traffic with three held entries ----------------
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle(1'b0);
      disp_valid = 1'b1; disp_opcode = 5'(k + 1);
      disp_src1_prf = 6'(k); disp_src1_ready = 1'b1;
      disp_src2_prf = 6'(k); disp_src2_ready = 1'b1;
      disp_dest_prf = 6'(60 + k);
    end
    @(negedge clk);
    idle(1'b0);
    #1;
    chk("held_count", 100, 32'(count), 32'd3);
    chk("held_dest", 100, 32'(issue_dest_prf), 32'd60);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 101, 32'(issue_valid), 32'd0);
    chk("async_rst_count", 101, 32'(count), 32'd0);
    chk("async_rst_dest", 101, 32'(issue_dest_prf), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", 102, 32'(disp_ready), 32'd1);
    chk("post_rst_count", 102, 32'(count), 32'd0);

    // queue usable after reset
    @(negedge clk);
    idle(1'b1);
    disp_valid = 1'b1; disp_opcode = 5'd2;
    disp_src1_prf = 6'd0; disp_src1_ready = 1'b1;
    disp_src2_prf = 6'd0; disp_src2_ready = 1'b1;
    disp_dest_prf = 6'd33;
    @(negedge clk);
    idle(1'b1);
    #1;
    chk("post_rst_issue", 103, 32'(issue_valid), 32'd1);
    chk("post_rst_dest", 103, 32'(issue_dest_prf), 32'd33);
    @(negedge clk);
    idle(1'b0);
    #1;
    chk("post_rst_drain", 104, 32'(count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
